wbi_cmd_arbiter: RTL

Round-robin arbiter that shares one downstream command/response channel between NM upstream master-node command ports, using valid/ready handshakes on both paths. It sits between the master nodes' command/response FIFO ports and a single slave-side port. The grant is held for a whole transaction: all write-burst beats, or one read command plus its complete response burst up to the last-burst flag. Only one transaction is outstanding at a time.

---
 rtl/wbi_cmd_arbiter_pkg.sv | 15 +
 rtl/wbi_cmd_arbiter_rr_pick.sv | 15 +
 rtl/wbi_cmd_arbiter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/wbi_cmd_arbiter_pkg.sv
// wbi_arb_pkg: shared FSM state type and round-robin pick function for the command arbiter
package wbi_arb_pkg;
    typedef enum logic [1:0] {IDLE, CMD, WRITE, RESP} state_t;
    function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr, input int nm);
        logic [2:0] idx;
        int k;
        idx = ptr;
        // walk offsets downward so the smallest offset from ptr wins
        for (int i = 7; i >= 0; i--) begin
            k = (int'(ptr) + i) % nm;
            if (i < nm && req[k[2:0]]) idx = k[2:0];
        end
        return idx;
    endfunction
endpackage

// File: rtl/wbi_cmd_arbiter_rr_pick.sv
// wbi_rr_pick: round-robin priority encoder; i_req/i_ptr in, o_idx winner and o_any out
module wbi_rr_pick
    import wbi_arb_pkg::*;
#(
    parameter int NM = 4,
    parameter int IW = 2
) (
    input  logic [NM-1:0] i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);
    assign o_idx = IW'(rr_pick(8'(i_req), 3'(i_ptr), NM));
    assign o_any = |i_req;
endmodule

// File: rtl/wbi_cmd_arbiter.sv
// wbi_cmd_arbiter: round-robin share of one cmd/resp channel among NM masters, grant held per transaction
// Ports: mclk/reset; m_cmd_* upstream command ports; m_res_* upstream responses (data/flags broadcast);
// s_cmd_*/s_res_* slave channel; gnt_o one-hot owner; tid_err_o sticky response-tid mismatch.
module wbi_cmd_arbiter
    import wbi_arb_pkg::*;
#(
    parameter int NM = 4,
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int BW = 4,
    parameter int BL = 10
) (
    input  logic             mclk,
    input  logic             reset,
    input  logic [NM-1:0]    m_cmd_wval_i,
    output logic [NM-1:0]    m_cmd_wrdy_o,
    input  logic [NM*AW-1:0] m_cmd_adr_i,
    input  logic [NM-1:0]    m_cmd_we_i,
    input  logic [NM*DW-1:0] m_cmd_dat_i,
    input  logic [NM*BW-1:0] m_cmd_sel_i,
    input  logic [NM*4-1:0]  m_cmd_tid_i,
    input  logic [NM*BL-1:0] m_cmd_bl_i,
    input  logic [NM-1:0]    m_res_rrdy_i,
    output logic [NM-1:0]    m_res_rval_o,
    output logic [DW-1:0]    m_res_dat_o,
    output logic             m_res_ack_o,
    output logic             m_res_lack_o,
    output logic             m_res_err_o,
    output logic [3:0]       m_res_tid_o,
    input  logic             s_cmd_wrdy_i,
    output logic             s_cmd_wval_o,
    output logic [AW-1:0]    s_cmd_adr_o,
    output logic             s_cmd_we_o,
    output logic [DW-1:0]    s_cmd_dat_o,
    output logic [BW-1:0]    s_cmd_sel_o,
    output logic [3:0]       s_cmd_tid_o,
    output logic [BL-1:0]    s_cmd_bl_o,
    output logic             s_res_rrdy_o,
    input  logic             s_res_rval_i,
    input  logic [DW-1:0]    s_res_dat_i,
    input  logic             s_res_ack_i,
    input  logic             s_res_lack_i,
    input  logic             s_res_err_i,
    input  logic [3:0]       s_res_tid_i,
    output logic [NM-1:0]    gnt_o,
    output logic             tid_err_o
);
    localparam int IW = (NM > 2) ? $clog2(NM) : 1;

    state_t        r_state;
    logic [IW-1:0] r_rr_ptr, r_gnt_idx;
    logic [BL-1:0] r_cnt;
    logic [3:0]    r_cap_tid;
    logic          r_tid_err;
    logic [IW-1:0] w_pick, w_next;
    logic          w_any, w_fwd, w_resp, w_beat, w_rsp;
    logic [NM-1:0] w_onehot;

    wbi_rr_pick #(.NM(NM), .IW(IW)) u_pick (
        .i_req (m_cmd_wval_i),
        .i_ptr (r_rr_ptr),
        .o_idx (w_pick),
        .o_any (w_any)
    );

    assign w_fwd    = (r_state == CMD) || (r_state == WRITE);
    assign w_resp   = r_state == RESP;
    assign w_onehot = NM'(1) << r_gnt_idx;
    assign w_next   = (r_gnt_idx == IW'(NM-1)) ? '0 : r_gnt_idx + IW'(1);

    assign s_cmd_adr_o = m_cmd_adr_i[int'(r_gnt_idx)*AW +: AW];
    assign s_cmd_we_o  = m_cmd_we_i[r_gnt_idx];
    assign s_cmd_dat_o = m_cmd_dat_i[int'(r_gnt_idx)*DW +: DW];
    assign s_cmd_sel_o = m_cmd_sel_i[int'(r_gnt_idx)*BW +: BW];
    assign s_cmd_tid_o = m_cmd_tid_i[int'(r_gnt_idx)*4 +: 4];
    assign s_cmd_bl_o  = m_cmd_bl_i[int'(r_gnt_idx)*BL +: BL];

    assign s_cmd_wval_o = w_fwd & m_cmd_wval_i[r_gnt_idx];
    assign m_cmd_wrdy_o = (w_fwd & s_cmd_wrdy_i) ? w_onehot : '0;
    assign s_res_rrdy_o = w_resp & m_res_rrdy_i[r_gnt_idx];
    assign m_res_rval_o = (w_resp & s_res_rval_i) ? w_onehot : '0;
    assign gnt_o        = (r_state != IDLE) ? w_onehot : '0;
    assign tid_err_o    = r_tid_err;

    assign m_res_dat_o  = s_res_dat_i;
    assign m_res_ack_o  = s_res_ack_i;
    assign m_res_lack_o = s_res_lack_i;
    assign m_res_err_o  = s_res_err_i;
    assign m_res_tid_o  = s_res_tid_i;

    assign w_beat = s_cmd_wval_o & s_cmd_wrdy_i;
    assign w_rsp  = s_res_rval_i & s_res_rrdy_o;

    always_ff @(posedge mclk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_rr_ptr  <= '0;
            r_gnt_idx <= '0;
            r_cnt     <= '0;
            r_cap_tid <= '0;
            r_tid_err <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (w_any) begin
                    r_gnt_idx <= w_pick;
                    r_state   <= CMD;
                end
                CMD: if (w_beat) begin
                    r_cap_tid <= s_cmd_tid_o;
                    if (!s_cmd_we_o) r_state <= RESP;
                    // a zero burst count behaves as a single beat
                    else if (s_cmd_bl_o <= BL'(1)) begin
                        r_state  <= IDLE;
                        r_rr_ptr <= w_next;
                    end else begin
                        r_cnt   <= s_cmd_bl_o - BL'(1);
                        r_state <= WRITE;
                    end
                end
                WRITE: if (w_beat) begin
                    r_cnt <= r_cnt - BL'(1);
                    if (r_cnt == BL'(1)) begin
                        r_state  <= IDLE;
                        r_rr_ptr <= w_next;
                    end
                end
                RESP: if (w_rsp) begin
                    if (s_res_tid_i != r_cap_tid) r_tid_err <= 1'b1;
                    if (s_res_lack_i) begin
                        r_state  <= IDLE;
                        r_rr_ptr <= w_next;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
